instr_program_writer: RTL

//  Host-side instruction encoder and program loader for the simple processor. It is the writer
//  for the instruction memory that the processor's IR decode stage reads. It accepts decoded

---
 rtl/proc_isa_pkg.sv | 26 ++
 rtl/instr_program_writer_if.sv | 31 +++
 rtl/instr_program_writer_fifo.sv | 51 +++++
 rtl/instr_program_writer.sv | 127 ++++++++++++
 4 files changed

// File: rtl/proc_isa_pkg.sv
// Shared ISA definitions for the simple processor: opcodes, IR field positions and loader FSM states.
// The IR decode stage and the host-side program writer both import this package.
package proc_isa_pkg;

  localparam logic [4:0] OP_MOVSGPR = 5'd0;
  localparam logic [4:0] OP_MOV     = 5'd1;
  localparam logic [4:0] OP_ADD     = 5'd2;
  localparam logic [4:0] OP_SUB     = 5'd3;
  localparam logic [4:0] OP_MUL     = 5'd4;

  localparam int OPER_LSB  = 27;
  localparam int RDST_LSB  = 22;
  localparam int RSRC1_LSB = 17;
  localparam int IMM_BIT   = 16;
  localparam int RSRC2_LSB = 11;
  localparam int REG_W     = 5;
  localparam int ISRC_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ipw_state_e;

endpackage

// File: rtl/instr_program_writer_if.sv
// Program-writer bus: decoded-instruction stream in, instruction-memory write port out.
// The master side is the host plus the instruction memory; the slave side is the writer.
interface instr_program_writer_if #(parameter int ADDR_W = 4);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_oper;
  logic [4:0]        in_rdst;
  logic [4:0]        in_rsrc1;
  logic              in_imm_mode;
  logic [4:0]        in_rsrc2;
  logic [15:0]       in_isrc;
  logic              in_last;
  logic              mem_we;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_oper, in_rdst, in_rsrc1, in_imm_mode, in_rsrc2, in_isrc, in_last,
    input  in_ready,
    input  mem_we, mem_addr, mem_wdata,
    output mem_ready
  );

  modport slave (
    input  in_valid, in_oper, in_rdst, in_rsrc1, in_imm_mode, in_rsrc2, in_isrc, in_last,
    output in_ready,
    output mem_we, mem_addr, mem_wdata,
    input  mem_ready
  );
endinterface

// File: rtl/instr_program_writer_fifo.sv
// Small first-word-fall-through FIFO for packed IR words; the head is visible while not empty.
// Read is combinational so a word pushed in one cycle reaches the write port the next.
module ipw_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wptr_q, wptr_d;
  logic [PTR_W:0]   rptr_q, rptr_d;
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                   (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[PTR_W-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[PTR_W-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
endmodule

// File: rtl/instr_program_writer.sv
// Packs decoded instruction fields into 32-bit IR words and loads them into instruction memory
// at sequential addresses, with a short FIFO absorbing memory backpressure.
module instr_program_writer
  import proc_isa_pkg::*;
#(
  parameter int PROG_DEPTH = 16,
  parameter int ADDR_W     = $clog2(PROG_DEPTH),
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 sys_rst,
  input  logic                 start,
  instr_program_writer_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err_illegal,
  output logic                 err_full,
  output logic [ADDR_W:0]      prog_len
);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(PROG_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = ADDR_W'(PROG_DEPTH - 1);

  ipw_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   prog_len_q, prog_len_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic              err_illegal_q, err_illegal_d;
  logic              err_full_q, err_full_d;

  logic        fifo_full, fifo_empty;
  logic [31:0] fifo_head;
  logic [31:0] packed_word;
  logic        hs, legal, room, push, pop;

  always_comb begin
    packed_word = '0;
    packed_word[OPER_LSB +: REG_W] = bus.in_oper;
    packed_word[RDST_LSB +: REG_W] = bus.in_rdst;
    if (bus.in_oper != OP_MOVSGPR) begin
      packed_word[RSRC1_LSB +: REG_W] = bus.in_rsrc1;
      packed_word[IMM_BIT]            = bus.in_imm_mode;
      if (bus.in_imm_mode)
        packed_word[0 +: ISRC_W] = bus.in_isrc;
      else if (bus.in_oper != OP_MOV)
        packed_word[RSRC2_LSB +: REG_W] = bus.in_rsrc2;
    end
  end

  // wcnt counts words committed to the FIFO, so overflow is caught before the words drain.
  assign hs    = bus.in_valid && bus.in_ready;
  assign legal = (bus.in_oper <= OP_MUL);
  assign room  = (wcnt_q != DEPTH_CNT);
  assign push  = hs && legal && room;
  assign pop   = bus.mem_we && bus.mem_ready;

  ipw_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (sys_rst),
    .push_i  (push),
    .wdata_i (packed_word),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    prog_len_d    = prog_len_q;
    wcnt_d        = wcnt_q;
    err_illegal_d = err_illegal_q;
    err_full_d    = err_full_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d       = ST_LOAD;
          addr_d        = '0;
          prog_len_d    = '0;
          wcnt_d        = '0;
          err_illegal_d = 1'b0;
          err_full_d    = 1'b0;
        end
      end
      ST_LOAD:  if (hs && bus.in_last) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
    if (pop) begin
      prog_len_d = prog_len_q + 1'b1;
      if (addr_q != ADDR_MAX) addr_d = addr_q + 1'b1;
    end
    if (push) wcnt_d = wcnt_q + 1'b1;
    if (hs && !legal) err_illegal_d = 1'b1;
    if (hs && legal && !room) err_full_d = 1'b1;
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      prog_len_q    <= '0;
      wcnt_q        <= '0;
      err_illegal_q <= 1'b0;
      err_full_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      prog_len_q    <= prog_len_d;
      wcnt_q        <= wcnt_d;
      err_illegal_q <= err_illegal_d;
      err_full_q    <= err_full_d;
    end
  end

  // Data is gated so the write port reads all-zero whenever no write is requested.
  assign bus.in_ready  = (state_q == ST_LOAD) && !fifo_full;
  assign bus.mem_we    = !fifo_empty;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = fifo_empty ? 32'd0 : fifo_head;

  assign busy        = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);
  assign err_illegal = err_illegal_q;
  assign err_full    = err_full_q;
  assign prog_len    = prog_len_q;
endmodule
